// File: rtl/router_src_arbiter_if.sv
// Source-side and router-side signals shared between N_SRC packet sources and router_top.
// master = sources plus router (stimulus side); slave = the arbiter.
interface router_src_arbiter_if #(
  parameter int N_SRC = 3
);
  logic [N_SRC-1:0]   src_req;
  logic [N_SRC-1:0]   src_pkt_valid;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_grant;
  logic [N_SRC-1:0]   src_busy;
  logic               busy;
  logic               pkt_valid;
  logic [7:0]         data_in;

  modport master (
    output src_req, src_pkt_valid, src_data, busy,
    input  src_grant, src_busy, pkt_valid, data_in
  );

  modport slave (
    input  src_req, src_pkt_valid, src_data, busy,
    output src_grant, src_busy, pkt_valid, data_in
  );
endinterface

// File: rtl/router_src_arbiter.sv
// Round-robin, packet-granular arbiter sharing one router_top input port among N_SRC sources.
//   state | meaning
//   IDLE  | no grant; pick next requester at/after rr pointer
//   GRANT | source granted, waiting for its header (start timeout running)
//   XFER  | forwarding header/payload until the parity byte is accepted
//   GAP   | enforced idle cycles between packets (also after a timeout)
module router_src_arbiter #(
  parameter int N_SRC         = 3,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  router_src_arbiter_if.slave    bus,
  output logic                   timeout_err,
  output logic [7:0]             pkt_count
);

  localparam int IW = $clog2(N_SRC);
  localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] grant;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    rr_ptr;
  logic [7:0]       tmo_cnt;
  logic [3:0]       gap_cnt;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic             any_grant;
  logic             cur_valid;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= 32'(N_SRC)) s = s - 32'(N_SRC);
    return s[IW-1:0];
  endfunction

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (bus.src_req[next_idx(rr_ptr, unsigned'(k))]) begin
        pick_vld = 1'b1;
        pick_idx = next_idx(rr_ptr, unsigned'(k));
      end
    end
  end

  assign any_grant     = |grant;
  assign cur_valid     = bus.src_pkt_valid[gidx];
  assign bus.src_grant = grant;
  assign bus.src_busy  = {N_SRC{bus.busy}} & grant;
  assign bus.pkt_valid = any_grant & cur_valid;
  assign bus.data_in   = any_grant ? bus.src_data[{gidx, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant   <= {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
            gidx    <= pick_idx;
            rr_ptr  <= next_idx(pick_idx, 1);
            tmo_cnt <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (cur_valid && !bus.busy) begin
            state <= XFER;
          end else if (tmo_cnt == TMO_LAST) begin
            grant       <= '0;
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        XFER: begin
          // pkt_valid low with the router ready marks the parity byte being taken.
          if (!cur_valid && !bus.busy) begin
            pkt_count <= pkt_count + 8'd1;
            grant     <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
